// File: rtl/invader_formation_mover_pkg.sv
// Shared formation types and dimensions for the mover, game controller and invader drawers.
package invader_formation_mover_pkg;
    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 16;
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int ALIVE_W  = $clog2(NUM_ROWS * NUM_COLS) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_R = 2'd1,
        MOVE_L = 2'd2,
        LANDED = 2'd3
    } state_e;
endpackage

// File: rtl/invader_formation_mover_mask_extent.sv
// Combinational extents of the alive mask: outermost live columns, lowest live row, live count.
module inv_mask_extent
    import invader_formation_mover_pkg::*;
(
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] inv_exs,
    output logic [COL_W-1:0]                  l_col,
    output logic [COL_W-1:0]                  r_col,
    output logic [ROW_W-1:0]                  b_row,
    output logic [ALIVE_W-1:0]                alive,
    output logic                              any_alive
);
    logic [NUM_COLS-1:0] col_any;
    logic [NUM_ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        alive   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                col_any[c] = col_any[c] | inv_exs[r][c];
                row_any[r] = row_any[r] | inv_exs[r][c];
                alive      = alive + ALIVE_W'(inv_exs[r][c]);
            end
        end
    end

    // Later loop iterations win, so scan direction picks lowest or highest index.
    always_comb begin
        l_col = '0;
        r_col = '0;
        b_row = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--)
            if (col_any[c]) l_col = COL_W'(c);
        for (int c = 0; c < NUM_COLS; c++)
            if (col_any[c]) r_col = COL_W'(c);
        for (int r = 0; r < NUM_ROWS; r++)
            if (row_any[r]) b_row = ROW_W'(r);
    end

    assign any_alive = |row_any;
endmodule

// File: rtl/invader_formation_mover.sv
// Marches the invader formation sideways, drops it at a border, speeds up as invaders die.
module invader_formation_mover
    import invader_formation_mover_pkg::*;
#(
    parameter int CELL_W     = 32,
    parameter int CELL_H     = 24,
    parameter int START_X    = 64,
    parameter int START_Y    = 48,
    parameter int STEP_X     = 8,
    parameter int STEP_Y     = 16,
    parameter int L_BORDER   = 5,
    parameter int R_BORDER   = 635,
    parameter int B_LIMIT    = 400,
    parameter int PERIOD_MAX = 32,
    parameter int PERIOD_MIN = 2
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  logic                              enable,
    input  logic                              restart,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0] invExs,
    output logic [10:0]                       invOSX,
    output logic [10:0]                       invOSY,
    output logic                              movDir,
    output logic                              stepPulse,
    output logic                              landed
);
    logic [COL_W-1:0]   l_col, r_col;
    logic [ROW_W-1:0]   b_row;
    logic [ALIVE_W-1:0] alive;
    logic               any_alive;

    inv_mask_extent u_extent (
        .inv_exs  (invExs),
        .l_col    (l_col),
        .r_col    (r_col),
        .b_row    (b_row),
        .alive    (alive),
        .any_alive(any_alive)
    );

    state_e      state_q, state_d;
    logic [10:0] osx_q, osx_d, osy_q, osy_d, osy_desc;
    logic [5:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d, pulse_q, pulse_d, landed_q, landed_d;
    logic [11:0] period, r_edge, l_edge, b_edge;
    logic        count_en, tick, descend;

    always_comb begin
        period   = 12'(PERIOD_MIN) + ((12'(alive) * 12'(PERIOD_MAX - PERIOD_MIN)) >> 7);
        r_edge   = 12'(osx_q) + (12'(r_col) + 12'd1) * 12'(CELL_W) + 12'(STEP_X);
        l_edge   = 12'(osx_q) + 12'(l_col) * 12'(CELL_W);
        osy_desc = osy_q + 11'(STEP_Y);
        b_edge   = 12'(osy_desc) + (12'(b_row) + 12'd1) * 12'(CELL_H);
        count_en = startOfFrame && enable && any_alive &&
                   (state_q == MOVE_R || state_q == MOVE_L);
        // >= rather than == so a period that shrank below the count still fires.
        tick     = count_en && (12'(cnt_q) >= period - 12'd1);

        state_d  = state_q;
        osx_d    = osx_q;
        osy_d    = osy_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        pulse_d  = 1'b0;
        landed_d = landed_q;
        descend  = 1'b0;

        if (restart) begin
            state_d  = IDLE;
            osx_d    = 11'(START_X);
            osy_d    = 11'(START_Y);
            cnt_d    = '0;
            dir_d    = 1'b1;
            landed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (enable) state_d = MOVE_R;
                MOVE_R, MOVE_L: begin
                    if (tick) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        if (state_q == MOVE_R) begin
                            if (r_edge > 12'(R_BORDER)) begin
                                descend = 1'b1;
                                dir_d   = 1'b0;
                                state_d = MOVE_L;
                            end else begin
                                osx_d = osx_q + 11'(STEP_X);
                            end
                        end else begin
                            if (l_edge < 12'(L_BORDER + STEP_X)) begin
                                descend = 1'b1;
                                dir_d   = 1'b1;
                                state_d = MOVE_R;
                            end else begin
                                osx_d = osx_q - 11'(STEP_X);
                            end
                        end
                    end else if (count_en) begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: ;
            endcase
            if (descend) begin
                osy_d = osy_desc;
                if (b_edge >= 12'(B_LIMIT)) begin
                    landed_d = 1'b1;
                    state_d  = LANDED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            osx_q    <= 11'(START_X);
            osy_q    <= 11'(START_Y);
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            pulse_q  <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            osx_q    <= osx_d;
            osy_q    <= osy_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            pulse_q  <= pulse_d;
            landed_q <= landed_d;
        end
    end

    assign invOSX    = osx_q;
    assign invOSY    = osy_q;
    assign movDir    = dir_q;
    assign stepPulse = pulse_q;
    assign landed    = landed_q;
endmodule

// File: tb/tb_invader_formation_mover.sv
// Directed bench for invader_formation_mover: march, descend, landing, speed-up, restart, reset.
module tb_invader_formation_mover;
    import invader_formation_mover_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic enable = 1'b0;
    logic restart = 1'b0;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] invExs = '0;
    logic [10:0] invOSX, invOSY;
    logic movDir, stepPulse, landed;

    invader_formation_mover dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (enable),
        .restart     (restart),
        .invExs      (invExs),
        .invOSX      (invOSX),
        .invOSY      (invOSY),
        .movDir      (movDir),
        .stepPulse   (stepPulse),
        .landed      (landed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One frame: startOfFrame for one cycle, then one quiet cycle. Called at a negedge.
    task automatic frame(output logic pulsed);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        pulsed = stepPulse;
        @(negedge clk);
    endtask

    task automatic step(input string tag, output int n);
        logic p;
        p = 1'b0;
        n = 0;
        while (!p && n < 100) begin
            frame(p);
            n++;
        end
        if (!p) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, cnt, pulses;
        logic p;

        repeat (2) @(negedge clk);
        check("rst_x", invOSX, 64);
        check("rst_y", invOSY, 48);
        check("rst_dir", movDir, 1);
        check("rst_pulse", stepPulse, 0);
        check("rst_landed", landed, 0);
        resetN = 1'b1;

        // Full formation, rightward march
        invExs = '1;
        enable = 1'b1;
        @(negedge clk);
        step("s1", n);
        check("s1_frames", n, 32);
        check("s1_x", invOSX, 72);
        for (int i = 2; i <= 7; i++) step("r", n);
        check("s7_x", invOSX, 120);
        check("s7_y", invOSY, 48);
        step("s8", n);
        check("d1_x", invOSX, 120);
        check("d1_y", invOSY, 64);
        check("d1_dir", movDir, 0);

        // Leftward march
        for (int i = 0; i < 14; i++) step("l", n);
        check("l14_x", invOSX, 8);
        step("d2", n);
        check("d2_y", invOSY, 80);
        check("d2_dir", movDir, 1);

        // March until landing on the 10th descend
        cnt = 0;
        while (!landed && cnt < 200) begin
            step("land", n);
            cnt++;
        end
        check("land_steps", cnt, 120);
        check("land_y", invOSY, 208);
        check("land_x", invOSX, 8);
        check("land_flag", landed, 1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            frame(p);
            pulses += int'(p);
        end
        check("frozen_pulses", pulses, 0);
        check("frozen_x", invOSX, 8);
        check("frozen_y", invOSY, 208);
        check("frozen_landed", landed, 1);

        // Restart from LANDED
        enable = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rs_x", invOSX, 64);
        check("rs_y", invOSY, 48);
        check("rs_landed", landed, 0);
        check("rs_dir", movDir, 1);

        // Single invader: fastest period, far-right border
        invExs = '0;
        invExs[0][0] = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        step("a1", n);
        check("a1_frames", n, 2);
        check("a1_x", invOSX, 72);
        step("a1b", n);
        check("a1b_frames", n, 2);
        cnt = 0;
        while (movDir && cnt < 100) begin
            step("a1r", n);
            cnt++;
        end
        check("a1_rsteps", cnt, 66);
        check("a1_desc_x", invOSX, 600);
        check("a1_desc_y", invOSY, 64);
        cnt = 0;
        while (invOSX != 11'd40 && cnt < 200) begin
            step("a1l", n);
            cnt++;
        end
        check("a1_lsteps", cnt, 70);
        check("a1_l_dir", movDir, 0);

        // Restart coincides with a step tick in MOVE_L at x=40
        frame(p);
        check("pre_rs_pulse", p, 0);
        startOfFrame = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        restart = 1'b0;
        check("rt_x", invOSX, 64);
        check("rt_y", invOSY, 48);
        check("rt_dir", movDir, 1);
        check("rt_pulse", stepPulse, 0);

        // Mask halves mid-count: period 32 -> 17 with counter at 20
        invExs = '1;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            frame(p);
            pulses += int'(p);
        end
        check("mc_prepulses", pulses, 0);
        for (int r = 4; r < NUM_ROWS; r++) invExs[r] = '0;
        frame(p);
        check("mc_pulse", p, 1);
        check("mc_x", invOSX, 72);

        // Asynchronous reset between clock edges
        #1 resetN = 1'b0;
        #1;
        check("ar_x", invOSX, 64);
        check("ar_y", invOSY, 48);
        check("ar_dir", movDir, 1);
        check("ar_pulse", stepPulse, 0);
        @(negedge clk);
        resetN = 1'b1;

        // No live invaders: no steps
        invExs = '0;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            frame(p);
            pulses += int'(p);
        end
        check("empty_pulses", pulses, 0);
        check("empty_x", invOSX, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
